// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their *W variants.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass the iteration.
module div_iter #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic             i_word,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic             word_q, neg_q_q, neg_r_q, dz_q, ovf_q;
    logic             ready_q, valid_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q, res_q;
    logic [CW-1:0]    cnt_q;

    function automatic logic [WIDTH-1:0] wext(input logic w, input logic [WIDTH-1:0] v);
        return w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Most-negative value at the op width, already sign-extended to WIDTH.
    function automatic logic [WIDTH-1:0] min_w(input logic w);
        return w ? {{(WIDTH-31){1'b1}}, {31{1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    logic             sgn, a_neg, b_neg, acc_dz, acc_ovf;
    logic [WIDTH-1:0] a_ext, b_ext, a_abs, b_abs, quo_ld;

    always_comb begin
        sgn     = ~i_op[0];
        a_ext   = i_word ? {{(WIDTH-32){sgn & i_dividend[31]}}, i_dividend[31:0]} : i_dividend;
        b_ext   = i_word ? {{(WIDTH-32){sgn & i_divisor[31]}}, i_divisor[31:0]} : i_divisor;
        a_neg   = sgn & a_ext[WIDTH-1];
        b_neg   = sgn & b_ext[WIDTH-1];
        a_abs   = a_neg ? -a_ext : a_ext;
        b_abs   = b_neg ? -b_ext : b_ext;
        acc_dz  = (b_ext == '0);
        acc_ovf = sgn & (a_ext == min_w(i_word)) & (b_ext == '1);
        // Word dividends sit at the top so 32 shifts move them fully through the remainder.
        quo_ld  = i_word ? {a_abs[31:0], {(WIDTH-32){1'b0}}} : a_abs;
    end

    logic [WIDTH:0] trial;
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};

    logic [WIDTH-1:0] q_fix, r_fix, fix_res;

    // The signed magnitude path gets these corners wrong, so they are forced here.
    always_comb begin
        q_fix = neg_q_q ? -quo_q : quo_q;
        r_fix = neg_r_q ? -rem_q : rem_q;
        if (dz_q) begin
            q_fix = '1;
        end
        if (ovf_q) begin
            q_fix = min_w(word_q);
            r_fix = '0;
        end
        fix_res = wext(word_q, op_q[1] ? r_fix : q_fix);
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic [WIDTH-1:0] fast_res;
    always_comb begin
        if (i_op[1]) begin
            fast_res = wext(i_word, acc_dz ? a_ext : '0);
        end else begin
            fast_res = wext(i_word, acc_dz ? '1 : a_ext);
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else if (i_flush) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_q    <= i_op;
                        word_q  <= i_word;
                        neg_q_q <= a_neg ^ b_neg;
                        neg_r_q <= a_neg;
                        dz_q    <= acc_dz;
                        ovf_q   <= acc_ovf;
                        rem_q   <= '0;
                        quo_q   <= quo_ld;
                        div_q   <= b_abs;
                        cnt_q   <= i_word ? CW'(32) : CW'(WIDTH);
                        ready_q <= 1'b0;
`ifdef DIV_FAST_SPECIAL_EN
                        if (acc_dz || acc_ovf) begin
                            res_q   <= fast_res;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem_q <= trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    res_q   <= fix_res;
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = res_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corners, handshake/flush/reset scenarios and random ops
// against a plain-arithmetic RISC-V division model.
module tb_div_iter;
    logic        i_clk = 1'b0;
    logic        i_rst, i_flush, i_valid, i_word, i_ready;
    logic [1:0]  i_op;
    logic [63:0] i_dividend, i_divisor;
    logic        o_ready, o_valid;
    logic [63:0] o_result;

    int checks = 0;
    int passes = 0;

`ifdef DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    div_iter #(.WIDTH(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_word(i_word), .i_dividend(i_dividend), .i_divisor(i_divisor),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // RISC-V M-extension semantics with native SV arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0] q32, r32;
        logic [63:0] q64, r64;
        int          sa, sb;
        longint      la, lb;
        if (w) begin
            sa = a[31:0];
            sb = b[31:0];
            if (b[31:0] == 32'd0) begin
                q32 = '1; r32 = a[31:0];
            end else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hffff_ffff) begin
                q32 = a[31:0]; r32 = '0;
            end else if (!op[0]) begin
                q32 = sa / sb; r32 = sa % sb;
            end else begin
                q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
            end
            return op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end
        la = a;
        lb = b;
        if (b == 64'd0) begin
            q64 = '1; r64 = a;
        end else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = '0;
        end else if (!op[0]) begin
            q64 = la / lb; r64 = la % lb;
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return op[1] ? r64 : q64;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        bit corner;
        if (w) corner = (b[31:0] == 0) || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        else   corner = (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
        if (FAST && corner) return 1;
        return w ? 34 : 66;
    endfunction

    // Presents one request for a single accept edge; returns one cycle after it.
    task automatic start(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        i_op = op; i_word = w; i_dividend = a; i_divisor = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!o_valid && lat < 120) begin
            @(posedge i_clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
        int lat;
        chk({tag, "/ready_in"}, {63'd0, o_ready}, 64'd1);
        start(op, w, a, b);
        wait_valid(lat);
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat(op, w, a, b)));
        chk({tag, "/result"}, o_result, model(op, w, a, b));
        chk({tag, "/ready_busy"}, {63'd0, o_ready}, 64'd0);
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk({tag, "/valid_drop"}, {63'd0, o_valid}, 64'd0);
    endtask

    task automatic abort_mid(input string tag, input bit use_rst);
        bit seen;
        start(2'b01, 1'b0, 64'd123456789, 64'd97);
        repeat (19) begin @(posedge i_clk); #1; end
        if (use_rst) i_rst = 1'b1; else i_flush = 1'b1;
        i_op = 2'b00; i_word = 1'b0; i_dividend = 64'd50; i_divisor = 64'd5; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        chk({tag, "/ready_after"}, {63'd0, o_ready}, 64'd1);
        chk({tag, "/valid_after"}, {63'd0, o_valid}, 64'd0);
        if (use_rst) chk({tag, "/result_rst"}, o_result, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        chk({tag, "/no_valid"}, {63'd0, seen}, 64'd0);
        run_op({tag, "/next"}, 2'b10, 1'b0, -64'sd1000, 64'd7);
    endtask

    initial begin
        int          lat;
        logic [63:0] held, a, b;
        logic [1:0]  op;
        logic        w;
        bit          stable;

        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_op = '0; i_word = 1'b0; i_dividend = '0; i_divisor = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("reset/ready", {63'd0, o_ready}, 64'd1);
        chk("reset/valid", {63'd0, o_valid}, 64'd0);
        chk("reset/result", o_result, 64'd0);

        run_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7);
        run_op("remu_100_7", 2'b11, 1'b0, 64'd100, 64'd7);
        run_op("div_m7_2", 2'b00, 1'b0, -64'sd7, 64'd2);
        run_op("rem_m7_2", 2'b10, 1'b0, -64'sd7, 64'd2);
        run_op("divuw_sext", 2'b01, 1'b1, 64'h0000_0000_8000_0000, 64'd1);
        run_op("div_by0", 2'b00, 1'b0, 64'd5, 64'd0);
        run_op("rem_by0", 2'b10, 1'b0, 64'd5, 64'd0);
        run_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, '1);
        run_op("divw_ovf", 2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_ffff_ffff);
        run_op("remw_by0", 2'b10, 1'b1, 64'h0000_0000_f000_0001, 64'hffff_ffff_0000_0000);

        // Consumer back-pressure in DONE.
        start(2'b00, 1'b1, 64'd1000, -64'sd3);
        wait_valid(lat);
        chk("hold/valid", {63'd0, o_valid}, 64'd1);
        held = o_result;
        stable = 1'b1;
        repeat (10) begin
            @(posedge i_clk); #1;
            if (o_result !== held || o_ready !== 1'b0 || o_valid !== 1'b1) stable = 1'b0;
        end
        chk("hold/stable", {63'd0, stable}, 64'd1);
        chk("hold/result", held, model(2'b00, 1'b1, 64'd1000, -64'sd3));
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("hold/ready_next", {63'd0, o_ready}, 64'd1);
        run_op("hold/after", 2'b11, 1'b1, 64'hdead_beef_0000_0123, 64'd10);

        abort_mid("flush", 1'b0);
        abort_mid("rst", 1'b1);

        // Flush on the same edge as the result handshake.
        start(2'b01, 1'b1, 64'd77, 64'd5);
        wait_valid(lat);
        i_ready = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0; i_flush = 1'b0;
        chk("flush_done/valid", {63'd0, o_valid}, 64'd0);
        chk("flush_done/ready", {63'd0, o_ready}, 64'd1);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = 64'($signed($urandom_range(0, 16)) - 8);
                1: b = w ? {$urandom, 32'd0} : 64'd0;
                2: begin
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = w ? {$urandom, 32'hffff_ffff} : '1;
                end
                3: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            run_op($sformatf("rand%0d", n), op, w, a, b);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative radix-2 restoring divider for the RV64M execution unit. It implements DIV/DIVU/REM/REMU and their 32-bit word variants. It sits beside the Wallace-tree multiplier in the EXU and is the inverse-operation unit to it. It accepts one operation through a valid/ready handshake, iterates one quotient bit per cycle, applies RISC-V sign and corner-case rules, and holds the result until the consumer takes it.

## Interface
- WIDTH, 64, operand and result width; word ops use the low 32 bits.
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_flush  in  1  abort any in-flight operation (pipeline redirect)
- i_valid  in  1  operation request
- o_ready  out  1  high only in IDLE; request accepted when i_valid & o_ready
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_word  in  1  32-bit (*W) variant
- i_dividend  in  WIDTH  rs1
- i_divisor  in  WIDTH  rs2
- o_valid  out  1  result available
- i_ready  in  1  consumer accepts result when o_valid & i_ready
- o_result  out  WIDTH  quotient or remainder

## Operation
- States are IDLE, CALC, FIX and DONE.
- **IDLE**
  - On accept, latch the op and the word flag.
  - Form operands: word ops take bits [31:0], sign-extended for signed ops and zero-extended for unsigned ops.
  - Signed ops store the absolute values, plus neg_q = sign(a)^sign(b) and neg_r = sign(a).
  - Load the remainder register with 0 and the quotient register with |a|.
  - Load iteration counter with N, where N=32 for word ops and N=WIDTH otherwise.
  - Go to CALC.
- **CALC**, each cycle:
  - Shift {rem,quo} left 1.
  - Compute trial = rem_shifted − |b| at WIDTH+1 bits.
  - If trial ≥ 0: rem=trial and quo[0]=1; else quo[0]=0.
  - Decrement the counter. When it reaches 0, go to FIX.
- **FIX**
  - Negate quo if neg_q, and negate rem if neg_r (signed ops only).
  - Select quo for DIV/DIVU and rem for REM/REMU.
  - For word ops, sign-extend bit 31 of the result to WIDTH; this applies to DIVUW/REMUW too.
  - Register into o_result and go to DONE.
- **DONE**
  - o_valid=1 and o_result is held stable.
  - On i_ready, go to IDLE.
- **Corner cases**, required results after FIX:
  - Divisor zero: quotient all-ones, remainder = dividend (word-extended).
  - Signed overflow (most-negative ÷ −1, at the op width): quotient = dividend, remainder 0.
  - The plain iteration plus FIX does not produce these results for signed ops, so they are detected at accept and forced in FIX.
- **i_flush**
  - Has priority over everything.
  - Next state is IDLE; o_valid drops the next cycle.
  - Any request presented the same cycle as i_flush is not accepted.
- **Reset values:** o_ready=1, o_valid=0, o_result=0, state IDLE, internal registers 0.

## Timing
- Cycle 0 is the accept edge. CALC runs cycles 1..N, FIX is cycle N+1, and o_valid first goes high in cycle N+2.
  - WIDTH=64 ops: latency 66.
  - Word ops: latency 34.
- Back-to-back:
  - Result handshake in cycle k returns the unit to IDLE, so o_ready is high in cycle k+1.
  - There is no same-cycle accept while in DONE.
- o_result changes only on the FIX→DONE edge, or on the fast-path edge.
- A flush in any cycle, including the same cycle as the result handshake, yields IDLE with o_valid=0 the next cycle.
- Reset asserted mid-operation gives reset values on the next edge, regardless of state.

## Configuration
- DIV_FAST_SPECIAL_EN
  - **Defined:** at accept, divisor-zero and signed-overflow cases skip CALC/FIX.
    - The corner result is registered directly and state goes IDLE→DONE, so o_valid is high in cycle 1.
  - **Undefined:** these cases take the full N+2 latency, with the forced values applied in FIX.
- Results are identical either way; only latency differs.

## Test plan
- DIVU 64-bit, dividend 100, divisor 7 → o_valid in cycle 66, o_result=14. REMU on the same operands → 2.
- DIV, dividend −7, divisor 2 → −3 (0xFFFF_FFFF_FFFF_FFFD). REM on the same operands → −1. Check the remainder sign follows the dividend.
- DIVUW, dividend 0x0000_0000_8000_0000, divisor 1 → latency 34, o_result=0xFFFF_FFFF_8000_0000 (sign-extended).
- Corner cases, with both macro settings; check latency 1 vs 66:
  - DIV by 0, dividend 5 → all-ones.
  - REM by 0, dividend 5 → 5.
  - DIV 0x8000_0000_0000_0000 ÷ −1 → 0x8000_0000_0000_0000.
  - REM on the same operands → 0.
- Hold i_ready low 10 cycles in DONE → o_result stable and o_ready=0. Assert i_ready → o_ready high the next cycle, and a new op is accepted.
- Assert i_flush at CALC cycle 20 with i_valid also high → o_valid never rises for either op, o_ready=1 next cycle, and the following op returns the correct value. Repeat with i_rst instead of i_flush.
